tb_unit_213: RTL and testbench

- Block-based traceback unit for the (2,1,3) Viterbi decoder.
- Buffers one frame of per-state survivor decision vectors from the ACS array.
- At the last step of the frame, latches the minimum-metric state produced by the traceback decision stage.
- Traces the survivor path backwards one step per cycle, then emits the decoded bits in forward (time) order over a valid/ready handshake.

---
 rtl/tb_unit_213.sv | 110 +++++++++++
 tb/tb_tb_unit_213.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/tb_unit_213.sv
// Block traceback unit for the (2,1,3) Viterbi decoder: buffers one frame of
// survivor decisions, traces back from the best state, then streams bits in time order.
module tb_unit_213 #(
  parameter int M     = 3,
  parameter int FRAME = 16,
  parameter int AW    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [(1<<M)-1:0]   dec_in,
  input  logic                dec_valid,
  output logic                dec_ready,
  input  logic [M-1:0]        best_state,
  output logic                out_bit,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                busy
);
  localparam int NS = 1 << M;
  localparam logic [AW-1:0] LAST_IDX = AW'(FRAME-1);

  typedef enum logic [1:0] {COLLECT, TRACE, EMIT} st_t;

  st_t               state_q, state_d;
  logic [AW-1:0]     wr_cnt_q, rd_idx_q, em_idx_q, em_nxt;
  logic [M-1:0]      tb_state_q;
  logic              out_bit_q, out_valid_q, out_last_q;
  logic [NS-1:0]     mem [FRAME];
  logic [FRAME-1:0]  obuf;
  logic              wr_en, emit_hs;

  assign dec_ready = (state_q == COLLECT);
  assign busy      = (state_q != COLLECT);
  assign out_bit   = out_bit_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign wr_en     = dec_valid && dec_ready;
  assign emit_hs   = out_valid_q && out_ready;
  assign em_nxt    = em_idx_q + AW'(1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (wr_en && wr_cnt_q == LAST_IDX) state_d = TRACE;
      TRACE:   if (rd_idx_q == '0) state_d = EMIT;
      EMIT:    if (emit_hs && out_last_q) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= COLLECT;
    else     state_q <= state_d;
  end

  // Storage arrays carry no reset; a stale frame is never read before being rewritten.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_cnt_q] <= dec_in;
    if (state_q == TRACE) obuf[rd_idx_q] <= tb_state_q[M-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q    <= '0;
      rd_idx_q    <= '0;
      em_idx_q    <= '0;
      tb_state_q  <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: if (wr_en) begin
          if (wr_cnt_q == LAST_IDX) begin
            wr_cnt_q   <= '0;
            tb_state_q <= best_state;
            rd_idx_q   <= LAST_IDX;
          end else begin
            wr_cnt_q <= wr_cnt_q + AW'(1);
          end
        end
        TRACE: begin
          tb_state_q <= {tb_state_q[M-2:0], mem[rd_idx_q][tb_state_q]};
          if (rd_idx_q == '0) em_idx_q <= '0;
          else                rd_idx_q <= rd_idx_q - AW'(1);
        end
        EMIT: begin
          // First EMIT cycle only loads the output register, giving FRAME+1 latency.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_bit_q   <= obuf[em_idx_q];
            out_last_q  <= (em_idx_q == LAST_IDX);
          end else if (out_ready) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_bit_q   <= 1'b0;
            end else begin
              em_idx_q   <= em_nxt;
              out_bit_q  <= obuf[em_nxt];
              out_last_q <= (em_nxt == LAST_IDX);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_tb_unit_213.sv
// Scoreboard bench for tb_unit_213: directed frames push hand-computed bits,
// a negedge monitor pops and compares on each output handshake.
module tb_tb_unit_213;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dec_in;
  logic       dec_valid;
  logic       dec_ready;
  logic [2:0] best_state;
  logic       out_bit, out_valid, out_ready, out_last, busy;

  int n_pass = 0;
  int n_tot  = 0;
  int n_hs   = 0;
  logic [1:0] sb[$];  // {last, bit}

  localparam logic [15:0] EXP_ZERO = 16'hA000;  // dec=00, best=101
  localparam logic [15:0] EXP_ONES = 16'h1FFF;  // dec=FF, best=000

  tb_unit_213 #(.M(3), .FRAME(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .dec_in(dec_in), .dec_valid(dec_valid),
    .dec_ready(dec_ready), .best_state(best_state), .out_bit(out_bit),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    logic [1:0] e;
    if (!rst && out_valid && out_ready) begin
      n_hs++;
      if (sb.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("out_bit", int'(out_bit), int'(e[0]));
        chk("out_last", int'(out_last), int'(e[1]));
      end
    end
  end

  task automatic push_exp(input logic [15:0] bits);
    for (int i = 0; i < 16; i++) sb.push_back({(i == 15), bits[i]});
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [2:0] bs,
                            input bit tog, input bit hold);
    for (int i = 0; i < 16; i++) begin
      if (tog) begin
        dec_valid = 1'b0;
        dec_in    = ~d;
        @(posedge clk); #1;
      end
      dec_valid  = 1'b1;
      dec_in     = d;
      best_state = (i == 15) ? bs : ~bs;
      @(posedge clk); #1;
    end
    if (!hold) dec_valid = 1'b0;
    chk("busy_after_last_write", int'(busy), 1);
  endtask

  task automatic check_latency();
    repeat (16) @(posedge clk);
    #1 chk("valid_low_at_16", int'(out_valid), 0);
    @(posedge clk); #1;
    chk("valid_high_at_17", int'(out_valid), 1);
    chk("dec_ready_in_emit", int'(dec_ready), 0);
  endtask

  task automatic drain(input bit hold);
    bit done = 0;
    bit rdy_ok = 1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge clk); #1;
      if (busy && dec_ready) rdy_ok = 0;
      if (sb.size() == 0 && !out_valid && !busy) done = 1;
    end
    if (hold) begin
      dec_valid = 1'b0;
      chk("dec_ready_low_while_busy", int'(rdy_ok), 1);
    end
    chk("drain_complete", int'(done), 1);
    chk("idle_dec_ready", int'(dec_ready), 1);
  endtask

  initial begin
    int base;
    bit hit;
    rst = 1'b1; dec_in = '0; dec_valid = 1'b0; best_state = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dec_ready", int'(dec_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_out_bit", int'(out_bit), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;

    // 1: all-zero decisions
    push_exp(EXP_ZERO);
    send_frame(8'h00, 3'b101, 0, 0);
    check_latency();
    drain(0);

    // 2: all-one decisions
    push_exp(EXP_ONES);
    send_frame(8'hFF, 3'b000, 0, 0);
    check_latency();
    drain(0);

    // 3: dec_valid toggling
    push_exp(EXP_ZERO);
    send_frame(8'h00, 3'b101, 1, 0);
    check_latency();
    drain(0);

    // 4: dec_valid held high through TRACE/EMIT with junk data, then a clean frame
    push_exp(EXP_ZERO);
    send_frame(8'h00, 3'b101, 0, 1);
    dec_in = 8'h55;
    drain(1);
    push_exp(EXP_ONES);
    send_frame(8'hFF, 3'b000, 0, 0);
    drain(0);

    // 5: consumer stall at bit 7
    push_exp(EXP_ONES);
    base = n_hs;
    send_frame(8'hFF, 3'b000, 0, 0);
    hit = 0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(posedge clk); #1;
      if (n_hs == base + 7) begin
        out_ready = 1'b0;
        hit = 1;
      end
    end
    chk("stall_reached", int'(hit), 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_bit", int'(out_bit), int'(EXP_ONES[7]));
      chk("stall_last", int'(out_last), 0);
    end
    chk("stall_no_handshake", n_hs - base, 7);
    out_ready = 1'b1;
    drain(0);
    chk("stall_total_bits", n_hs - base, 16);

    // 6: reset in the middle of TRACE, then a full frame
    send_frame(8'hFF, 3'b000, 0, 0);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_dec_ready", int'(dec_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    push_exp(EXP_ZERO);
    send_frame(8'h00, 3'b101, 0, 0);
    check_latency();
    drain(0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
